// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath
//   Two-stage register-file + ALU datapath. An operation issued on one rising
//   edge (in_valid=1) has its operands read from the register file and
//   latched into the EX register. On the following edge the ALU result and
//   flags are registered onto the outputs and the result is written back.
//   The EX-stage result is forwarded to a dependent operation issuing in the
//   same cycle. Register 0 is hard-wired to zero.
//
// Ports
//   clock                   in   sole clock, rising edge
//   reset                   in   asynchronous, active-low reset
//   in_valid                in   one operation issued this cycle
//   read_reg_num1/2         in   source register addresses A / B
//   write_reg               in   destination register address
//   alu_control             in   4-bit operation select
//   regwrite                in   write result to write_reg
//   out_valid               out  alu_result and flags valid this cycle
//   alu_result              out  registered ALU result
//   zero/negative/carry/overflow_flag  out  registered status flags
// ---------------------------------------------------------------------------
module pipelined_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [$clog2(NREG)-1:0]  read_reg_num1,
  input  logic [$clog2(NREG)-1:0]  read_reg_num2,
  input  logic [$clog2(NREG)-1:0]  write_reg,
  input  logic [3:0]               alu_control,
  input  logic                     regwrite,
  output logic                     out_valid,
  output logic [XLEN-1:0]          alu_result,
  output logic                     zero_flag,
  output logic                     negative_flag,
  output logic                     carry_flag,
  output logic                     overflow_flag
);

  localparam int AW  = $clog2(NREG);
  localparam int SHW = $clog2(XLEN);
  localparam int MSB = XLEN - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
  localparam logic [AW-1:0]   ZERO_A = {AW{1'b0}};

  // Register file
  logic [XLEN-1:0] regs_q [NREG];

  // EX stage register
  logic            ex_valid_q,    ex_valid_d;
  logic            ex_regwrite_q, ex_regwrite_d;
  logic [AW-1:0]   ex_wreg_q,     ex_wreg_d;
  logic [3:0]      ex_ctrl_q,     ex_ctrl_d;
  logic [XLEN-1:0] ex_a_q,        ex_a_d;
  logic [XLEN-1:0] ex_b_q,        ex_b_d;

  // Output stage register
  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_result_q,  out_result_d;
  logic            out_zero_q,    out_zero_d;
  logic            out_neg_q,     out_neg_d;
  logic            out_carry_q,   out_carry_d;
  logic            out_ovf_q,     out_ovf_d;

  // EX-stage combinational ALU
  logic [XLEN-1:0] ex_result_s;
  logic            ex_legal_s;
  logic            ex_carry_s;
  logic            ex_ovf_s;
  logic            ex_zero_s;
  logic            ex_neg_s;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   diff_s;
  logic [SHW-1:0]  shamt_s;
  logic            ex_wen_s;

  // Issue-stage operand path
  logic [XLEN-1:0] rf_a_s, rf_b_s;
  logic [XLEN-1:0] op_a_s, op_b_s;

  // An illegal opcode writes nothing, so it is also never a forwarding source;
  // the nonzero-address term keeps r0 out of both paths.
  assign ex_wen_s = ex_valid_q & ex_regwrite_q & ex_legal_s & (ex_wreg_q != ZERO_A);

  // Register file read with r0 forced to zero and EX-stage forwarding
  always_comb begin
    rf_a_s = ZERO_W;
    rf_b_s = ZERO_W;
    op_a_s = ZERO_W;
    op_b_s = ZERO_W;
    if (read_reg_num1 == ZERO_A) begin
      rf_a_s = ZERO_W;
    end else begin
      rf_a_s = regs_q[read_reg_num1];
    end
    if (read_reg_num2 == ZERO_A) begin
      rf_b_s = ZERO_W;
    end else begin
      rf_b_s = regs_q[read_reg_num2];
    end
    // Forwarding also covers the same-edge write/read of one register.
    if (ex_wen_s && (ex_wreg_q == read_reg_num1)) begin
      op_a_s = ex_result_s;
    end else begin
      op_a_s = rf_a_s;
    end
    if (ex_wen_s && (ex_wreg_q == read_reg_num2)) begin
      op_b_s = ex_result_s;
    end else begin
      op_b_s = rf_b_s;
    end
  end

  // EX register next state; regwrite is qualified by in_valid here
  always_comb begin
    ex_valid_d    = in_valid;
    ex_regwrite_d = in_valid & regwrite;
    ex_wreg_d     = write_reg;
    ex_ctrl_d     = alu_control;
    ex_a_d        = op_a_s;
    ex_b_d        = op_b_s;
  end

  // ALU: result, legality and arithmetic flags from the EX operands
  always_comb begin
    sum_s       = {1'b0, ex_a_q} + {1'b0, ex_b_q};
    // diff_s[XLEN] is the unsigned borrow (A < B).
    diff_s      = {1'b0, ex_a_q} - {1'b0, ex_b_q};
    shamt_s     = ex_b_q[SHW-1:0];
    ex_result_s = ZERO_W;
    ex_legal_s  = 1'b1;
    ex_carry_s  = 1'b0;
    ex_ovf_s    = 1'b0;
    case (ex_ctrl_q)
      OP_AND:  ex_result_s = ex_a_q & ex_b_q;
      OP_OR:   ex_result_s = ex_a_q | ex_b_q;
      OP_XOR:  ex_result_s = ex_a_q ^ ex_b_q;
      OP_NOR:  ex_result_s = ~(ex_a_q | ex_b_q);
      OP_ADD: begin
        ex_result_s = sum_s[XLEN-1:0];
        ex_carry_s  = sum_s[XLEN];
        ex_ovf_s    = (ex_a_q[MSB] == ex_b_q[MSB]) && (sum_s[MSB] != ex_a_q[MSB]);
      end
      OP_SUB: begin
        ex_result_s = diff_s[XLEN-1:0];
        ex_carry_s  = diff_s[XLEN];
        ex_ovf_s    = (ex_a_q[MSB] != ex_b_q[MSB]) && (diff_s[MSB] != ex_a_q[MSB]);
      end
      OP_SLL:  ex_result_s = ex_a_q << shamt_s;
      OP_SRL:  ex_result_s = ex_a_q >> shamt_s;
      OP_SRA:  ex_result_s = $signed(ex_a_q) >>> shamt_s;
      OP_SLT:  ex_result_s = {{(XLEN-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
      OP_SLTU: ex_result_s = {{(XLEN-1){1'b0}}, (ex_a_q < ex_b_q)};
      default: begin
        ex_result_s = ZERO_W;
        ex_legal_s  = 1'b0;
      end
    endcase
    ex_zero_s = (ex_result_s == ZERO_W);
    ex_neg_s  = ex_result_s[MSB];
  end

  // Output next state: capture on a valid EX op, otherwise hold last values
  always_comb begin
    out_valid_d = ex_valid_q;
    if (ex_valid_q) begin
      out_result_d = ex_result_s;
      out_zero_d   = ex_zero_s;
      out_neg_d    = ex_neg_s;
      out_carry_d  = ex_carry_s;
      out_ovf_d    = ex_ovf_s;
    end else begin
      out_result_d = out_result_q;
      out_zero_d   = out_zero_q;
      out_neg_d    = out_neg_q;
      out_carry_d  = out_carry_q;
      out_ovf_d    = out_ovf_q;
    end
  end

  // EX stage register; reset drops any in-flight operation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_wreg_q     <= ZERO_A;
      ex_ctrl_q     <= 4'b0000;
      ex_a_q        <= ZERO_W;
      ex_b_q        <= ZERO_W;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_wreg_q     <= ex_wreg_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
    end
  end

  // Output stage register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= ZERO_W;
      out_zero_q   <= 1'b0;
      out_neg_q    <= 1'b0;
      out_carry_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_neg_q    <= out_neg_d;
      out_carry_q  <= out_carry_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  // Register file: reset loads register i with i, write-back from EX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= XLEN'(i);
      end
    end else if (ex_wen_s) begin
      regs_q[ex_wreg_q] <= ex_result_s;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_result    = out_result_q;
  assign zero_flag     = out_zero_q;
  assign negative_flag = out_neg_q;
  assign carry_flag    = out_carry_q;
  assign overflow_flag = out_ovf_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// ---------------------------------------------------------------------------
// tb_pipelined_datapath
//   Directed-vector bench for pipelined_datapath (XLEN=32, NREG=32).
//   The stimulus thread pushes the hand-computed result/flags of every issued
//   operation into a queue; a monitor pops and compares whenever out_valid is
//   seen on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipelined_datapath;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  read_reg_num1;
  logic [4:0]  read_reg_num2;
  logic [4:0]  write_reg;
  logic [3:0]  alu_control;
  logic        regwrite;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        negative_flag;
  logic        carry_flag;
  logic        overflow_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Expected entry: {result[31:0], zero, negative, carry, overflow}
  logic [35:0] exp_q [$];

  pipelined_datapath #(.XLEN(32), .NREG(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard head
  always @(negedge clock) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got result 0x%0h with no expected entry", alu_result);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("result", {32'h0, alu_result}, {32'h0, e[35:4]});
        check("flags_znCV", {60'h0, zero_flag, negative_flag, carry_flag, overflow_flag},
              {60'h0, e[3:0]});
      end
    end
  end

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SLT = 4'b0111;
  localparam logic [3:0] SRA = 4'b1000, SLTU = 4'b1001, NOR_ = 4'b1100, BAD = 4'b1010;

  task automatic issue(input logic [3:0] op, input int a, input int b, input int wr,
                       input logic rw, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clock);
    in_valid      = 1'b1;
    alu_control   = op;
    read_reg_num1 = 5'(a);
    read_reg_num2 = 5'(b);
    write_reg     = 5'(wr);
    regwrite      = rw;
    exp_q.push_back({er, ef});
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    regwrite = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    read_reg_num1 = 5'd0;
    read_reg_num2 = 5'd0;
    write_reg = 5'd0;
    alu_control = 4'b0000;
    regwrite = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_result", {32'h0, alu_result}, 64'd0);
    check("rst_flags", {60'h0, zero_flag, negative_flag, carry_flag, overflow_flag}, 64'd0);
    reset = 1'b1;

    //     op    A   B   W  rw  result        {z,n,c,v}
    issue(ADD,   1,  2,  0, 0, 32'h00000003, 4'b0000);
    issue(SUB,   1,  2,  0, 0, 32'hFFFFFFFF, 4'b0110);
    issue(ADD,   1,  2,  3, 1, 32'h00000003, 4'b0000);
    issue(ADD,   3,  3,  0, 0, 32'h00000006, 4'b0000);
    issue(SLL,   1, 31,  5, 1, 32'h80000000, 4'b0100);
    issue(ADD,   5,  5,  0, 0, 32'h00000000, 4'b1011);
    issue(SLT,   5,  1,  0, 0, 32'h00000001, 4'b0000);
    issue(SLTU,  5,  1,  0, 0, 32'h00000000, 4'b1000);
    issue(ADD,   1,  2,  0, 1, 32'h00000003, 4'b0000);
    issue(ADD,   0,  0,  0, 0, 32'h00000000, 4'b1000);
    issue(AND_,  6,  7,  0, 0, 32'h00000006, 4'b0000);
    issue(OR_,   5,  6,  0, 0, 32'h80000006, 4'b0100);
    issue(XOR_, 12, 10,  0, 0, 32'h00000006, 4'b0000);
    issue(SRL,   5,  4,  0, 0, 32'h08000000, 4'b0000);
    issue(SRA,   5,  4,  0, 0, 32'hF8000000, 4'b0100);
    issue(NOR_,  0,  0,  0, 0, 32'hFFFFFFFF, 4'b0100);
    issue(SUB,   5,  1,  0, 0, 32'h7FFFFFFF, 4'b0001);
    issue(SUB,   6,  1, 11, 1, 32'h00000005, 4'b0000);
    issue(ADD,  11,  0,  0, 0, 32'h00000005, 4'b0000);
    issue(BAD,   1,  2,  9, 1, 32'h00000000, 4'b1000);
    issue(ADD,   9,  0,  0, 0, 32'h00000009, 4'b0000);
    // Idle cycle with regwrite high: must not write r10
    @(negedge clock);
    in_valid = 1'b0;
    alu_control = ADD;
    read_reg_num1 = 5'd1;
    read_reg_num2 = 5'd1;
    write_reg = 5'd10;
    regwrite = 1'b1;
    issue(ADD,  10,  0,  0, 0, 32'h0000000A, 4'b0000);
    issue(ADD,  11,  0,  0, 0, 32'h00000005, 4'b0000);
    issue(SUB,   0,  1, 13, 1, 32'hFFFFFFFF, 4'b0110);
    issue(ADD,  13,  1,  0, 0, 32'h00000000, 4'b1010);
    issue(SLL,   1,  5,  0, 0, 32'h00000001, 4'b0000);
    issue(SLL,   2,  3,  0, 0, 32'h00000010, 4'b0000);
    idle();
    drain("drain_main");

    // Outputs hold their last values while out_valid is low
    check("hold_out_valid", {63'h0, out_valid}, 64'd0);
    check("hold_result", {32'h0, alu_result}, 64'h10);

    // Reset asserted while ADD r1,r2 -> r7 is in EX
    @(negedge clock);
    in_valid = 1'b1;
    alu_control = ADD;
    read_reg_num1 = 5'd1;
    read_reg_num2 = 5'd2;
    write_reg = 5'd7;
    regwrite = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    regwrite = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    check("midrst_result", {32'h0, alu_result}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_out_valid", {63'h0, out_valid}, 64'd0);

    issue(ADD,   7,  0,  0, 0, 32'h00000007, 4'b0000);
    issue(ADD,   5,  0,  0, 0, 32'h00000005, 4'b0000);
    issue(ADD,  13,  0,  0, 0, 32'h0000000D, 4'b0000);
    idle();
    drain("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and register width in bits (legal range 8..64).
REQ-002 SHALL have parameter NREG, default 32, meaning number of registers (power of 2, 4..64); AW = log2(NREG).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port in_valid  input  1  high for one operation per cycle.
REQ-006 SHALL have port read_reg_num1  input  AW  source register A.
REQ-007 SHALL have port read_reg_num2  input  AW  source register B.
REQ-008 SHALL have port write_reg  input  AW  destination register.
REQ-009 SHALL have port alu_control  input  4  operation select.
REQ-010 SHALL have port regwrite  input  1  write the result to write_reg.
REQ-011 SHALL have port out_valid  output  1  alu_result and flags valid this cycle.
REQ-012 SHALL have port alu_result  output  XLEN  registered ALU result.
REQ-013 SHALL have port zero_flag, negative_flag, carry_flag, overflow_flag  output  1 each  registered flags.

Function
REQ-014 SHALL be a 2-stage pipeline.
- Edge N samples in_valid, the operands and the controls into the EX register.
- Edge N+1 registers the result and flags, asserts out_valid, and writes the register file.
- Latency is 1 cycle from issue edge to output; throughput is 1 operation per cycle.
REQ-015 SHALL read operands from the register file combinationally at issue.
REQ-016 SHALL bypass the EX-stage ALU result to an issuing operand when all of these hold:
- EX is valid;
- EX regwrite is 1;
- EX write_reg equals that operand's address;
- the address is nonzero.
REQ-017 SHALL hold register 0 at constant 0: writes to it are ignored, it is never a bypass source, and it always reads 0.
REQ-018 SHALL decode alu_control as follows:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1100 NOR.
- All other codes give result 0 and write nothing.
REQ-019 SHALL take the shift amount from the low log2(XLEN) bits of operand B.
REQ-020 SHALL compute results modulo 2^XLEN; SLT and SLTU produce 1 or 0, zero-extended.
REQ-021 SHALL set the flags as follows:
- zero = (result == 0);
- negative = result[XLEN-1];
- carry = carry-out for ADD, borrow (A < B unsigned) for SUB, 0 otherwise;
- overflow = signed overflow for ADD/SUB, 0 otherwise.
REQ-022 SHALL hold alu_result and the flags at their last values while out_valid is 0.
REQ-023 SHALL ignore regwrite when in_valid is 0.
REQ-024 SHALL, on a same-edge write and read of one register, return the new value (via REQ-016).

Reset
REQ-025 SHALL, while reset = 0, asynchronously:
- clear out_valid and the EX valid bit;
- set alu_result and all flags to 0;
- load register i with value i (register 0 = 0).
REQ-026 SHALL drop any in-flight operation when reset asserts mid-operation: it is neither written nor output.
REQ-027 SHALL ignore in_valid on the first rising edge at which reset is 1 only if reset deasserted less than a setup time before it; otherwise it accepts issue normally.

Verification (XLEN=32, NREG=32)
REQ-028 Reset release, then issue ADD r1,r2, regwrite=0 -> one cycle later out_valid=1, alu_result=3, all flags 0; r-file unchanged.
REQ-029 Issue SUB r1,r2 -> alu_result=0xFFFFFFFF, negative=1, carry=1, zero=0, overflow=0.
REQ-030 Back-to-back: ADD r1,r2 -> r3, then next cycle ADD r3,r3 -> second result 6, via the bypass.
REQ-031 The following sequence SHALL give these results:
- SLL r1,r31 -> r5 gives 0x80000000;
- ADD r5,r5 gives 0 with zero=1, carry=1, overflow=1;
- SLT r5,r1 gives 1;
- SLTU r5,r1 gives 0.
REQ-032 ADD r1,r2 -> r0, then ADD r0,r0 -> result 0 (no bypass, no write).
REQ-033 Issue ADD r1,r2 -> r7, then assert reset before the next edge -> out_valid stays 0, r7 reads 7 after release.
